// File: rtl/plic_gateway_if.sv
// Interrupt-side and target-side signals of the PLIC gateway bundled as one port.
// master = the side driving interrupts and claim/complete; slave = the gateway.
interface plic_gateway_if #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 4
);
    logic [NUM_SRC-1:0] src_irq;
    logic [NUM_SRC-1:0] src_mode;
    logic               claim_vld;
    logic [ID_W-1:0]    claim_id;
    logic               cmpl_vld;
    logic [ID_W-1:0]    cmpl_id;
    logic [NUM_SRC-1:0] gate;
    logic [NUM_SRC-1:0] inflight;
    logic [NUM_SRC-1:0] ovf;

    modport master (
        output src_irq, src_mode, claim_vld, claim_id, cmpl_vld, cmpl_id,
        input  gate, inflight, ovf
    );

    modport slave (
        input  src_irq, src_mode, claim_vld, claim_id, cmpl_vld, cmpl_id,
        output gate, inflight, ovf
    );
endinterface

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: one IDLE/REQ/BUSY FSM per source, with an edge
// counter so rising edges arriving while a request is outstanding are replayed.
module plic_gw_src #(
    parameter int SRC_ID = 1,
    parameter int ID_W   = 4,
    parameter int CNT_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq,
    input  logic            mode,
    input  logic            claim_vld,
    input  logic [ID_W-1:0] claim_id,
    input  logic            cmpl_vld,
    input  logic [ID_W-1:0] cmpl_id,
    output logic            gate,
    output logic            inflight,
    output logic            ovf
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_BUSY = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ID_W-1:0]  MY_ID   = ID_W'(SRC_ID);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             src_d;
    logic             edge_now;
    logic             claim_hit;
    logic             cmpl_hit;

    assign edge_now  = irq & ~src_d;
    assign claim_hit = claim_vld && (claim_id == MY_ID);
    assign cmpl_hit  = cmpl_vld && (cmpl_id == MY_ID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            src_d    <= 1'b0;
            gate     <= 1'b0;
            inflight <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            src_d <= irq;
            ovf   <= 1'b0;
            // Edges seen while a request is outstanding are banked for replay.
            if (mode && edge_now && state != S_IDLE) begin
                if (cnt == CNT_MAX) ovf <= 1'b1;
                else                cnt <= cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (mode ? (edge_now || cnt != '0) : irq) begin
                        state <= S_REQ;
                        gate  <= 1'b1;
                        if (mode && !edge_now) cnt <= cnt - 1'b1;
                    end
                end
                S_REQ: begin
                    if (claim_hit) begin
                        state    <= S_BUSY;
                        gate     <= 1'b0;
                        inflight <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (cmpl_hit) begin
                        state    <= S_IDLE;
                        inflight <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    gate     <= 1'b0;
                    inflight <= 1'b0;
                end
            endcase
        end
    end
endmodule

module plic_gateway #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 4,
    parameter int CNT_W   = 3
) (
    input  logic          clk,
    input  logic          rst,
    plic_gateway_if.slave bus
);
    logic [NUM_SRC-1:0] gate_w;
    logic [NUM_SRC-1:0] inflight_w;
    logic [NUM_SRC-1:0] ovf_w;

    // Source IDs start at 1; ID 0 and IDs above NUM_SRC match no instance.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        plic_gw_src #(
            .SRC_ID (i + 1),
            .ID_W   (ID_W),
            .CNT_W  (CNT_W)
        ) u_src (
            .clk       (clk),
            .rst       (rst),
            .irq       (bus.src_irq[i]),
            .mode      (bus.src_mode[i]),
            .claim_vld (bus.claim_vld),
            .claim_id  (bus.claim_id),
            .cmpl_vld  (bus.cmpl_vld),
            .cmpl_id   (bus.cmpl_id),
            .gate      (gate_w[i]),
            .inflight  (inflight_w[i]),
            .ovf       (ovf_w[i])
        );
    end

    assign bus.gate     = gate_w;
    assign bus.inflight = inflight_w;
    assign bus.ovf      = ovf_w;
endmodule

// File: tb/tb_plic_gateway.sv
// Directed scenarios plus a random phase, checked against a per-source
// request/claim/backlog model of the gateway.
module tb_plic_gateway;
    localparam int NS    = 8;
    localparam int IDW   = 4;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    plic_gateway_if #(.NUM_SRC(NS), .ID_W(IDW)) bus ();

    plic_gateway #(.NUM_SRC(NS), .ID_W(IDW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: outstanding request, whether it has been claimed, banked edges.
    bit          m_out  [NS];
    bit          m_clm  [NS];
    int          m_bank [NS];
    bit          m_prev [NS];
    logic [NS-1:0] m_ovf;
    int          ovf0_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_out[i] = 0; m_clm[i] = 0; m_bank[i] = 0; m_prev[i] = 0;
        end
        m_ovf = '0;
    endtask

    function automatic logic [NS-1:0] exp_gate();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_out[i] && !m_clm[i];
        return v;
    endfunction

    function automatic logic [NS-1:0] exp_infl();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_clm[i];
        return v;
    endfunction

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NS; i++) begin
            bit lvl, md, rise, ch, cp;
            lvl  = bus.src_irq[i];
            md   = bus.src_mode[i];
            rise = lvl && !m_prev[i];
            ch   = bus.claim_vld && (int'(bus.claim_id) == i + 1);
            cp   = bus.cmpl_vld && (int'(bus.cmpl_id) == i + 1);
            m_ovf[i] = 1'b0;
            if (m_out[i] && md && rise) begin
                if (m_bank[i] == CMAX) m_ovf[i] = 1'b1;
                else m_bank[i]++;
            end
            if (!m_out[i]) begin
                if (md ? (rise || m_bank[i] > 0) : lvl) begin
                    m_out[i] = 1;
                    m_clm[i] = 0;
                    if (md && !rise) m_bank[i]--;
                end
            end else if (!m_clm[i]) begin
                if (ch) m_clm[i] = 1;
            end else if (cp) begin
                m_out[i] = 0;
                m_clm[i] = 0;
            end
            m_prev[i] = lvl;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("gate", bus.gate, exp_gate());
        chk("inflight", bus.inflight, exp_infl());
        chk("ovf", bus.ovf, m_ovf);
        ovf0_seen += int'(bus.ovf[0]);
        bus.claim_vld = 1'b0;
        bus.cmpl_vld  = 1'b0;
    endtask

    task automatic claim(input int id);
        bus.claim_vld = 1'b1;
        bus.claim_id  = IDW'(id);
    endtask

    task automatic cmpl(input int id);
        bus.cmpl_vld = 1'b1;
        bus.cmpl_id  = IDW'(id);
    endtask

    task automatic pulse(input int idx);
        bus.src_irq[idx] = 1'b1;
        cyc();
        bus.src_irq[idx] = 1'b0;
        cyc();
    endtask

    // Serve every request on source idx for up to max_cyc cycles; returns count.
    task automatic drain(input int idx, input int max_cyc, output int n);
        n = 0;
        for (int t = 0; t < max_cyc; t++) begin
            if (bus.gate[idx]) begin
                n++;
                claim(idx + 1);
                cyc();
                cmpl(idx + 1);
            end
            cyc();
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_gate", bus.gate, '0);
        chk("rst_infl", bus.inflight, '0);
        chk("rst_ovf", bus.ovf, '0);
        cyc();
        #1 rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.src_irq   = '0;
        bus.src_mode  = 8'b0000_0001;
        bus.claim_vld = 1'b0;
        bus.claim_id  = '0;
        bus.cmpl_vld  = 1'b0;
        bus.cmpl_id   = '0;
        ovf0_seen     = 0;
        model_reset();
        #1;
        chk("por_gate", bus.gate, '0);
        chk("por_infl", bus.inflight, '0);
        cyc();
        cyc();
        #1 rst = 1'b0;

        // Level source 3: request, claim, complete with level still high.
        cyc();
        bus.src_irq[2] = 1'b1;
        cyc();
        chk("lvl_gate_up", bus.gate, 8'h04);
        cyc(); cyc();
        claim(3);
        cyc();
        chk("lvl_claimed_gate", bus.gate, 8'h00);
        chk("lvl_claimed_infl", bus.inflight, 8'h04);
        cyc(); cyc(); cyc();
        cmpl(3);
        cyc();
        chk("lvl_gap", bus.gate, 8'h00);
        cyc();
        chk("lvl_rereq", bus.gate, 8'h04);
        // Illegal handshakes leave every source untouched.
        claim(0);  cyc();
        claim(9);  cyc();
        cmpl(6);   cyc();
        cmpl(3);   cyc();
        chk("illegal_gate", bus.gate, 8'h04);
        chk("illegal_infl", bus.inflight, 8'h00);
        // Same ID claim+complete: only the legal transition fires each time.
        claim(3); cmpl(3); cyc();
        chk("same_id_busy", bus.inflight, 8'h04);
        bus.src_irq[2] = 1'b0;
        claim(3); cmpl(3); cyc();
        chk("same_id_idle", bus.inflight, 8'h00);
        cyc();
        chk("lvl_dropped", bus.gate, 8'h00);

        // Edge source 1: four edges while BUSY replay as four requests.
        pulse(0);
        claim(1); cyc();
        for (int k = 0; k < 4; k++) pulse(0);
        cmpl(1); cyc();
        drain(0, 40, n);
        chk("edge_replays", n, 4);

        // Saturation: nine edges while BUSY keep seven, two overflow pulses.
        pulse(0);
        claim(1); cyc();
        ovf0_seen = 0;
        for (int k = 0; k < 9; k++) pulse(0);
        chk("sat_ovf_pulses", ovf0_seen, 2);
        cmpl(1); cyc();
        drain(0, 60, n);
        chk("sat_replays", n, 7);

        // Simultaneous complete of 2 and claim of 5.
        bus.src_irq[1] = 1'b1;
        bus.src_irq[4] = 1'b1;
        cyc();
        claim(2); cyc();
        bus.src_irq[1] = 1'b0;
        bus.src_irq[4] = 1'b0;
        cmpl(2); claim(5); cyc();
        chk("simul_gate", bus.gate, 8'h00);
        chk("simul_infl", bus.inflight, 8'h10);
        cmpl(5); cyc();

        // Reset while source 4 is BUSY with three banked edges.
        bus.src_mode = 8'b0000_1001;
        pulse(3);
        claim(4); cyc();
        for (int k = 0; k < 3; k++) pulse(3);
        chk("pre_rst_infl", bus.inflight, 8'h08);
        #2 rst = 1'b1;
        bus.src_irq[0] = 1'b1;
        model_reset();
        #1;
        chk("async_gate", bus.gate, '0);
        chk("async_infl", bus.inflight, '0);
        cyc();
        #1 rst = 1'b0;
        cmpl(4);
        cyc();
        chk("post_rst_edge_req", bus.gate, 8'h01);
        chk("post_rst_cmpl_ignored", bus.inflight, 8'h00);
        bus.src_irq[0] = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        chk("banked_discarded", bus.gate[3], 1'b0);
        claim(1); cyc();
        cmpl(1); cyc();

        // Random phase.
        do_reset();
        bus.src_mode = NS'($urandom);
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 4) == 0) bus.src_irq[i] = ~bus.src_irq[i];
            if ($urandom_range(0, 2) == 0) claim($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < NS; i++) if (m_out[i] && !m_clm[i]) claim(i + 1);
            end
            if ($urandom_range(0, 2) == 0) cmpl($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0) begin
                for (int i = NS - 1; i >= 0; i--) if (m_clm[i]) cmpl(i + 1);
            end
            cyc();
            if (t == 1000) begin
                do_reset();
                bus.src_mode = NS'($urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
